pump_dispense_ctrl: RTL and testbench

Parametrised fuel-dispense controller for the automatic fuel-station system. It sits between the transaction logic (litre preset, fuel selection, start) and the per-fuel pump valve drivers. It meters a preset quantity as a whole number of litres, each litre taking a fixed number of clocks, and gates the selected pump line with the nozzle valve. Over the previous single-shot pump block it adds:
- N fuel channels;
- a real state machine;
- pause/resume on valve release with a timeout;
- abort;
- input validation;
- done/aborted status;
- a running dispensed count.

---
 rtl/pump_pkg.sv | 22 ++
 rtl/pump_rate_tick.sv | 36 +++
 rtl/pump_dispense_ctrl.sv | 135 +++++++++++++
 tb/tb_pump_dispense_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// Shared types, defaults and helpers for the fuel-dispense controller.
// Also used by the selection front-end to validate the one-hot fuel select.
package pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } pump_state_t;

  localparam int DEF_N_FUEL    = 3;
  localparam int DEF_LIT_W     = 24;
  localparam int DEF_RATE_CLKS = 5;
  localparam int DEF_PAUSE_MAX = 8;

  // Callers zero-extend their select vector; channel counts above 32 are not supported.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/pump_rate_tick.sv
// Litre pacing counter: strobe on the RATE_CLKS-th enabled clock, with hold and clear.
// Strobe is combinational from enable. Count holds while enable is low.
module pump_rate_tick
  import pump_pkg::*;
#(
  parameter int RATE_CLKS = DEF_RATE_CLKS
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int TW = (RATE_CLKS > 1) ? $clog2(RATE_CLKS) : 1;
  localparam logic [TW-1:0] LAST = TW'(RATE_CLKS - 1);

  logic [TW-1:0] tick_q, tick_d;

  assign strobe = en && (tick_q == LAST);

  always_comb begin
    tick_d = tick_q;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = strobe ? '0 : tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) tick_q <= '0;
    else        tick_q <= tick_d;
  end

endmodule

// File: rtl/pump_dispense_ctrl.sv
// Multi-channel fuel dispenser: meters a litre preset through a one-hot pump line, pauses on valve release.
// gas is combinational from valve and abort; start/err/done are one-cycle handshakes.
module pump_dispense_ctrl
  import pump_pkg::*;
#(
  parameter int N_FUEL    = DEF_N_FUEL,
  parameter int LIT_W     = DEF_LIT_W,
  parameter int RATE_CLKS = DEF_RATE_CLKS,
  parameter int PAUSE_MAX = DEF_PAUSE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              valve,
  input  logic [LIT_W-1:0]  lit,
  input  logic [N_FUEL-1:0] select,
  output logic [N_FUEL-1:0] gas,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [LIT_W-1:0]  dispensed
);

  localparam int PW = $clog2(PAUSE_MAX + 1);

  pump_state_t       state_q, state_d;
  logic [N_FUEL-1:0] sel_q, sel_d;
  logic [LIT_W-1:0]  target_q, target_d;
  logic [LIT_W-1:0]  disp_q, disp_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              aborted_q, aborted_d;
  logic              err_q, err_d;

  logic start_ok, tick_en, tick_clr, litre_stb;

  assign start_ok = is_onehot(32'(select)) && (lit != '0);
  // Abort freezes the tick so a same-cycle litre strobe cannot land.
  assign tick_en  = (state_q == ST_RUN) && valve && !abort;
  assign tick_clr = (state_q == ST_IDLE) && start && start_ok;

  pump_rate_tick #(.RATE_CLKS(RATE_CLKS)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (tick_en),
    .clr    (tick_clr),
    .strobe (litre_stb)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    target_d  = target_q;
    disp_d    = disp_q;
    pcnt_d    = pcnt_q;
    aborted_d = aborted_q;
    err_d     = 1'b0;
    gas       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            target_d  = lit;
            sel_d     = select;
            disp_d    = '0;
            pcnt_d    = '0;
            aborted_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (valve) begin
          gas = sel_q;
          if (litre_stb) begin
            disp_d = disp_q + LIT_W'(1);
            if (disp_q + LIT_W'(1) == target_q) state_d = ST_DONE;
          end
        end else begin
          pcnt_d  = '0;
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (valve) begin
          state_d = ST_RUN;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
          if (pcnt_q + PW'(1) == PW'(PAUSE_MAX)) begin
            aborted_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      target_q  <= '0;
      disp_q    <= '0;
      pcnt_q    <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      target_q  <= target_d;
      disp_q    <= disp_d;
      pcnt_q    <= pcnt_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;
  assign err       = err_q;
  assign dispensed = disp_q;

endmodule

// File: tb/tb_pump_dispense_ctrl.sv
// Scoreboarded bench for pump_dispense_ctrl: transaction-level outcome model, randomized valve/abort traffic.
// Expected done/err pulses are queued at issue and checked by an independent monitor.
module tb_pump_dispense_ctrl;

  localparam int N_FUEL    = 3;
  localparam int LIT_W     = 24;
  localparam int RATE_CLKS = 5;
  localparam int PAUSE_MAX = 8;
  localparam int VLEN      = 300;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic              valve;
  logic [LIT_W-1:0]  lit;
  logic [N_FUEL-1:0] select;
  logic [N_FUEL-1:0] gas;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;
  logic [LIT_W-1:0]  dispensed;

  pump_dispense_ctrl #(
    .N_FUEL(N_FUEL), .LIT_W(LIT_W), .RATE_CLKS(RATE_CLKS), .PAUSE_MAX(PAUSE_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .valve(valve),
    .lit(lit), .select(select), .gas(gas), .busy(busy), .done(done),
    .aborted(aborted), .err(err), .dispensed(dispensed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    bit ab;
    int disp;
    int gcnt;
    int at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   gas_cnt = 0;
  int   cur_sel = 0;
  int   last_disp = 0;
  bit   last_ab = 1'b0;
  bit   vpat [VLEN];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  // Outcome of one accepted transaction, walking the valve script cycle by cycle from the first busy cycle.
  function automatic void model(input int litres, input int abort_at, output int end_idx,
                                output bit ab, output int disp, output int gcnt);
    int  pumped = 0;
    int  closed = 0;
    bit  live   = 1'b1;
    end_idx = VLEN - 1; ab = 1'b0; disp = 0; gcnt = 0;
    for (int i = 0; i < VLEN; i++) begin
      if (i == abort_at) begin
        end_idx = i; ab = 1'b1; disp = pumped / RATE_CLKS; gcnt = pumped;
        return;
      end
      if (live) begin
        if (vpat[i]) begin
          pumped++;
          if (pumped == litres * RATE_CLKS) begin
            end_idx = i; ab = 1'b0; disp = litres; gcnt = pumped;
            return;
          end
        end else begin
          live = 1'b0; closed = 1;
        end
      end else if (vpat[i]) begin
        live = 1'b1; closed = 0;
      end else begin
        closed++;
        if (closed == PAUSE_MAX + 1) begin
          end_idx = i; ab = 1'b1; disp = pumped / RATE_CLKS; gcnt = pumped;
          return;
        end
      end
    end
  endfunction

  // Monitor: gas line purity every cycle, and scoreboard pop on every done/err pulse.
  always @(negedge clk) begin
    if (!reset) begin
      gas_cnt = 0;
    end else begin
      if (gas != '0) begin
        gas_cnt++;
        chk("gas_line", int'(gas), cur_sel);
      end
      if (done || err) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_pulse done=%0b err=%0b expected none cyc=%0d", done, err, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_is_err", int'(err), int'(e.is_err));
          chk("pulse_is_done", int'(done), int'(!e.is_err));
          chk("pulse_cycle", cyc, e.at_cyc);
          chk("aborted", int'(aborted), int'(e.ab));
          chk("dispensed", int'(dispensed), e.disp);
          chk("gas_cycles", gas_cnt, e.gcnt);
          chk("busy_at_pulse", int'(busy), 0);
        end
        gas_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int from, input int to, input bit v);
    for (int i = from; i <= to && i < VLEN; i++) vpat[i] = v;
  endtask

  task automatic gen_vpat();
    int i = 0;
    int len;
    int r;
    while (i < 150) begin
      len = $urandom_range(1, 8);
      fill(i, i + len - 1, 1'b1);
      i += len;
      r = $urandom_range(0, 9);
      if (r < 6)      len = $urandom_range(1, PAUSE_MAX);
      else if (r < 8) len = PAUSE_MAX;
      else            len = $urandom_range(PAUSE_MAX + 1, PAUSE_MAX + 3);
      fill(i, i + len - 1, 1'b0);
      i += len;
    end
    fill(i, VLEN - 1, 1'b1);
  endtask

  task automatic do_err(input int lit_v, input int sel_v);
    exp_t e;
    start = 1'b1; lit = LIT_W'(lit_v); select = N_FUEL'(sel_v); valve = 1'($urandom);
    e.is_err = 1'b1; e.ab = last_ab; e.disp = last_disp; e.gcnt = 0; e.at_cyc = cyc + 1;
    exp_q.push_back(e);
    step();
    start = 1'b0;
    step();
  endtask

  task automatic do_txn(input int lit_v, input int sel_v, input int abort_at, input int mid_start);
    exp_t e;
    int   end_idx;
    bit   ab;
    int   disp;
    int   gcnt;
    model(lit_v, abort_at, end_idx, ab, disp, gcnt);
    start = 1'b1; lit = LIT_W'(lit_v); select = N_FUEL'(sel_v); valve = 1'b0; abort = 1'b0;
    cur_sel = sel_v;
    e.is_err = 1'b0; e.ab = ab; e.disp = disp; e.gcnt = gcnt; e.at_cyc = cyc + end_idx + 2;
    exp_q.push_back(e);
    last_ab = ab; last_disp = disp;
    for (int i = 0; i <= end_idx; i++) begin
      step();
      start  = (i == mid_start);
      lit    = LIT_W'($urandom);
      select = N_FUEL'($urandom);
      valve  = vpat[i];
      abort  = (i == abort_at);
    end
    step();
    start = 1'b0; abort = 1'b0; valve = 1'($urandom);
    step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; valve = 1'b0; lit = '0; select = '0;
    step(); step();
    @(negedge clk);
    chk("rst_gas", int'(gas), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_dispensed", int'(dispensed), 0);
    step();
    reset = 1'b1;
    step();

    fill(0, VLEN - 1, 1'b1);
    do_txn(3, 3'b010, -1, -1);
    do_err(2, 3'b011);
    do_err(0, 3'b001);
    do_err(1, 3'b000);

    fill(0, VLEN - 1, 1'b1); fill(6, 9, 1'b0);
    do_txn(2, 3'b100, -1, -1);

    fill(0, VLEN - 1, 1'b1); fill(7, 30, 1'b0);
    do_txn(4, 3'b001, -1, -1);

    fill(0, VLEN - 1, 1'b1);
    do_txn(5, 3'b010, 12, 5);

    fill(0, VLEN - 1, 1'b1);
    fill(0, 4, 1'b1); fill(5, 5 + PAUSE_MAX - 2, 1'b0);
    do_txn(2, 3'b001, -1, -1);

    // Reset pulse in the middle of a run: outputs clear and no done is produced.
    start = 1'b1; lit = LIT_W'(3); select = 3'b001; valve = 1'b1; cur_sel = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 1'b0;
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_gas", int'(gas), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dispensed", int'(dispensed), 0);
    chk("midrst_done", int'(done), 0);
    last_disp = 0; last_ab = 1'b0;
    step();
    fill(0, VLEN - 1, 1'b1);
    do_txn(2, 3'b100, -1, -1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 6) == 0) begin
        if ($urandom_range(0, 1) == 0) do_err(0, 1 << $urandom_range(0, 2));
        else                           do_err($urandom_range(1, 4), (($urandom_range(0, 1) == 0) ? 0 : 3) << $urandom_range(0, 1));
      end else begin
        gen_vpat();
        do_txn($urandom_range(1, 4), 1 << $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1);
      end
    end

    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
